// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b datapath types: word, ALU operation select and the raw
// IR offset fields that feed the ADJ generators.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [10:0] lc3b_offset11;

  typedef enum logic [2:0] {
    alu_add    = 3'd0,
    alu_and    = 3'd1,
    alu_not    = 3'd2,
    alu_pass   = 3'd3,
    alu_sll    = 3'd4,
    alu_srl    = 3'd5,
    alu_sra    = 3'd6,
    alu_unused = 3'd7
  } lc3b_aluop;

endpackage

// File: rtl/lc3b_adj.sv
// ADJ offset generator: sign-extend an IR offset field to the datapath width
// and shift it left by one, so the result is a byte offset to a word address.
module lc3b_adj #(
  parameter int width     = 9,
  parameter int out_width = 16
) (
  input  logic [width-1:0]     in_off,
  output logic [out_width-1:0] adj
);

  // Replicate the sign bit above the field and append a zero LSB.
  assign adj = {{(out_width - width - 1){in_off[width-1]}}, in_off, 1'b0};

endmodule

// File: rtl/lc3b_exec_unit.sv
// LC-3b execute-stage arithmetic: 16-bit ALU, PC-relative target adder and
// ADJ6/9/11 offset generators, with pipeline-registered ALU and target copies.
//
// Pipeline advance: load is a plain enable with no handshake back-pressure.
// When load=1 at a rising clock edge the EX/MEM copies capture the current
// combinational results; when load=0 they hold (stall). reset_n=0 clears
// them asynchronously and overrides load.
module lc3b_exec_unit
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  lc3b_aluop        aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  lc3b_offset11     ir_off,
  input  logic             off_sel,
  output logic [WIDTH-1:0] alu_f,
  output logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] adj6,
  output logic [WIDTH-1:0] alu_q,
  output logic [WIDTH-1:0] target_q
);

  logic [WIDTH-1:0] adj9;
  logic [WIDTH-1:0] adj11;
  logic [WIDTH-1:0] pc_off;
  logic [3:0]       shamt;

  // Offset generators for LDR/STR (6), BR/LEA (9) and JSR (11).
  lc3b_adj #(.width(6),  .out_width(WIDTH)) u_adj6 (
    .in_off (ir_off[5:0]),
    .adj    (adj6)
  );

  lc3b_adj #(.width(9),  .out_width(WIDTH)) u_adj9 (
    .in_off (ir_off[8:0]),
    .adj    (adj9)
  );

  lc3b_adj #(.width(11), .out_width(WIDTH)) u_adj11 (
    .in_off (ir_off),
    .adj    (adj11)
  );

  // Only the low nibble of b is a shift count; upper bits are ignored.
  assign shamt = b[3:0];

  // ALU function select; the spare encoding yields zero.
  always_comb begin
    alu_f = '0;
    case (aluop)
      alu_add:  alu_f = a + b;
      alu_and:  alu_f = a & b;
      alu_not:  alu_f = ~a;
      alu_pass: alu_f = a;
      alu_sll:  alu_f = a << shamt;
      alu_srl:  alu_f = a >> shamt;
      alu_sra:  alu_f = $unsigned($signed(a) >>> shamt);
      default:  alu_f = '0;
    endcase
  end

  // PC-relative target; carry out of the top bit is dropped.
  assign pc_off = off_sel ? adj11 : adj9;
  assign target = pc + pc_off;

  // EX/MEM copies: async clear, capture on load, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_q    <= '0;
      target_q <= '0;
    end else if (load) begin
      alu_q    <= alu_f;
      target_q <= target;
    end
  end

endmodule

// File: tb/tb_lc3b_exec_unit.sv
// Self-checking bench for lc3b_exec_unit: directed cases plus randomized
// traffic checked against an arithmetic reference model.
module tb_lc3b_exec_unit;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  lc3b_aluop   aluop;
  logic [15:0] a, b, pc;
  logic [10:0] ir_off;
  logic        off_sel;
  logic [15:0] alu_f, target, adj6, alu_q, target_q;

  int n_cmp = 0;
  int n_err = 0;

  lc3b_exec_unit #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .aluop    (aluop),
    .a        (a),
    .b        (b),
    .pc       (pc),
    .ir_off   (ir_off),
    .off_sel  (off_sel),
    .alu_f    (alu_f),
    .target   (target),
    .adj6     (adj6),
    .alu_q    (alu_q),
    .target_q (target_q)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [15:0] m_alu(int op, longint av, longint bv);
    longint n, sa, r;
    n = bv % 16;
    case (op)
      0: r = (av + bv) % 65536;
      1: r = longint'(16'(av) & 16'(bv));
      2: r = 65535 - av;
      3: r = av;
      4: r = (av * (longint'(1) << n)) % 65536;
      5: r = av / (longint'(1) << n);
      6: begin
        sa = (av >= 32768) ? av - 65536 : av;
        r  = sa >>> n;
        r  = (r % 65536 + 65536) % 65536;
      end
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  function automatic longint m_adj(longint v, int w);
    longint s;
    s = v % (longint'(1) << w);
    if (s >= (longint'(1) << (w - 1))) s = s - (longint'(1) << w);
    return s * 2;
  endfunction

  function automatic logic [15:0] m_target(longint pcv, longint off, int sel);
    longint t;
    t = pcv + m_adj(off, sel ? 11 : 9);
    return 16'(((t % 65536) + 65536) % 65536);
  endfunction

  // ---------------- driver helpers ----------------
  task automatic drive(int op, logic [15:0] av, logic [15:0] bv,
                       logic [15:0] pcv, logic [10:0] offv, logic sel);
    aluop   = lc3b_aluop'(op[2:0]);
    a       = av;
    b       = bv;
    pc      = pcv;
    ir_off  = offv;
    off_sel = sel;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    load    = 1'b0;
    drive(3, 16'h1234, 16'h0000, 16'h3000, 11'h001, 1'b0);
    #1;
    n_cmp++;
    if (alu_q !== 16'h0000 || target_q !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_initial: alu_q=%h target_q=%h expected 0000/0000", alu_q, target_q);
    end
    @(negedge clk);
    reset_n = 1'b1;
    load    = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (alu_q !== 16'h1234 || target_q !== 16'h3002) begin
      n_err++;
      $display("FAIL reset_capture: alu_q=%h target_q=%h expected 1234/3002", alu_q, target_q);
    end
    // Mid-cycle async reset pulse: clears immediately, no clock edge needed.
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (alu_q !== 16'h0000 || target_q !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_async: alu_q=%h target_q=%h expected 0000/0000", alu_q, target_q);
    end
    // Reset held across an edge with load=1 must win.
    @(posedge clk); #1;
    n_cmp++;
    if (alu_q !== 16'h0000 || target_q !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_over_load: alu_q=%h target_q=%h expected 0000/0000", alu_q, target_q);
    end
    n_cmp++;
    if (alu_f !== 16'h1234 || target !== 16'h3002) begin
      n_err++;
      $display("FAIL reset_comb: alu_f=%h target=%h expected 1234/3002", alu_f, target);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    int          ops [10] = '{0, 0, 1, 2, 3, 7, 0, 1, 2, 3};
    logic [15:0] av  [10] = '{16'h7FFF, 16'hFFFF, 16'hF0F0, 16'h00FF, 16'h1234,
                             16'hABCD, 16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF};
    logic [15:0] bv  [10] = '{16'h0001, 16'h0001, 16'h0FF0, 16'h5555, 16'hFFFF,
                             16'h1111, 16'h8000, 16'h0000, 16'h1234, 16'h0000};
    logic [15:0] ev  [10] = '{16'h8000, 16'h0000, 16'h00F0, 16'hFF00, 16'h1234,
                             16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], av[i], bv[i], 16'h0000, 11'h000, 1'b0);
      #1;
      n_cmp++;
      if (alu_f !== ev[i]) begin
        n_err++;
        $display("FAIL alu_case%0d op%0d: alu_f=%h expected %h", i, ops[i], alu_f, ev[i]);
      end
    end
  endtask

  task automatic test_shifts();
    int          ops [6] = '{4, 5, 6, 4, 5, 6};
    logic [15:0] bv  [6] = '{16'h0004, 16'h0004, 16'h0004, 16'hFFF0, 16'hFFF0, 16'hFFF0};
    logic [15:0] ev  [6] = '{16'h0010, 16'h0800, 16'hF800, 16'h8001, 16'h8001, 16'h8001};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 16'h8001, bv[i], 16'h0000, 11'h000, 1'b0);
      #1;
      n_cmp++;
      if (alu_f !== ev[i]) begin
        n_err++;
        $display("FAIL shift_case%0d op%0d: alu_f=%h expected %h", i, ops[i], alu_f, ev[i]);
      end
    end
    // Maximum count 15 with upper bits of b set.
    drive(6, 16'h8000, 16'hABCF, 16'h0000, 11'h000, 1'b0);
    #1;
    n_cmp++;
    if (alu_f !== 16'hFFFF) begin
      n_err++;
      $display("FAIL shift_sra15: alu_f=%h expected FFFF", alu_f);
    end
  endtask

  task automatic test_target();
    logic [15:0] pcs [6] = '{16'h3000, 16'h3000, 16'h3000, 16'hFFFE, 16'h3000, 16'h0000};
    logic [10:0] offs[6] = '{11'h1FF, 11'h0FF, 11'h400, 11'h002, 11'h3FF, 11'h7FF};
    logic        sels[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // 0x400 as an 11-bit field is -1024, doubled to -2048: 0x3000-0x800.
    logic [15:0] ev  [6] = '{16'h2FFE, 16'h31FE, 16'h2800, 16'h0002, 16'h37FE, 16'hFFFE};
    for (int i = 0; i < 6; i++) begin
      drive(0, 16'h0000, 16'h0000, pcs[i], offs[i], sels[i]);
      #1;
      n_cmp++;
      if (target !== ev[i]) begin
        n_err++;
        $display("FAIL target_case%0d: target=%h expected %h", i, target, ev[i]);
      end
    end
    drive(0, 16'h0000, 16'h0000, 16'h0000, 11'h020, 1'b0);
    #1;
    n_cmp++;
    if (adj6 !== 16'hFFC0) begin
      n_err++;
      $display("FAIL adj6_min: adj6=%h expected FFC0", adj6);
    end
    drive(0, 16'h0000, 16'h0000, 16'h0000, 11'h7DF, 1'b0);
    #1;
    n_cmp++;
    if (adj6 !== 16'h003E) begin
      n_err++;
      $display("FAIL adj6_max: adj6=%h expected 003E", adj6);
    end
  endtask

  task automatic test_stall();
    logic [15:0] hold_alu, hold_tgt;
    @(negedge clk);
    load = 1'b1;
    drive(0, 16'h1111, 16'h2222, 16'h4000, 11'h010, 1'b0);
    @(posedge clk); #1;
    hold_alu = 16'h3333;
    hold_tgt = 16'h4020;
    n_cmp++;
    if (alu_q !== hold_alu || target_q !== hold_tgt) begin
      n_err++;
      $display("FAIL stall_prime: alu_q=%h target_q=%h expected %h/%h", alu_q, target_q, hold_alu, hold_tgt);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      load = 1'b0;
      drive(int'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
            16'($urandom), 11'($urandom), 1'($urandom));
      @(posedge clk); #1;
      n_cmp++;
      if (alu_q !== hold_alu || target_q !== hold_tgt) begin
        n_err++;
        $display("FAIL stall_hold%0d: alu_q=%h target_q=%h expected %h/%h", c, alu_q, target_q, hold_alu, hold_tgt);
      end
    end
    @(negedge clk);
    load = 1'b1;
    drive(1, 16'hFF00, 16'h0F0F, 16'h1000, 11'h100, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if (alu_q !== 16'h0F00 || target_q !== 16'h1200) begin
      n_err++;
      $display("FAIL stall_release: alu_q=%h target_q=%h expected 0F00/1200", alu_q, target_q);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_alu_q, exp_tgt_q, e_alu, e_tgt, e_adj6;
    int op;
    exp_alu_q = alu_q === 16'h0F00 ? 16'h0F00 : 16'h0F00;
    exp_tgt_q = 16'h1200;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      op   = int'($urandom_range(0, 7));
      load = 1'($urandom_range(0, 3) != 0);
      drive(op, 16'($urandom), 16'($urandom), 16'($urandom), 11'($urandom), 1'($urandom));
      e_alu  = m_alu(op, longint'(a), longint'(b));
      e_tgt  = m_target(longint'(pc), longint'(ir_off), int'(off_sel));
      e_adj6 = 16'(m_adj(longint'(ir_off), 6));
      #1;
      n_cmp++;
      if (alu_f !== e_alu || target !== e_tgt || adj6 !== e_adj6) begin
        n_err++;
        $display("FAIL rand_comb%0d op%0d a=%h b=%h pc=%h off=%h sel=%b: got %h/%h/%h expected %h/%h/%h",
                 i, op, a, b, pc, ir_off, off_sel, alu_f, target, adj6, e_alu, e_tgt, e_adj6);
      end
      if (load) begin
        exp_alu_q = e_alu;
        exp_tgt_q = e_tgt;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (alu_q !== exp_alu_q || target_q !== exp_tgt_q) begin
        n_err++;
        $display("FAIL rand_reg%0d load=%b: alu_q=%h target_q=%h expected %h/%h",
                 i, load, alu_q, target_q, exp_alu_q, exp_tgt_q);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu();
    test_shifts();
    test_target();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
